mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  synchronous reset, active-high
REQ-002 SHALL have these upstream ports, fed from the EX/MEM pipeline register:
  mem_valid  in  1  instruction present
  mem_wd  in  5  destination register
  mem_wreg  in  1  register write enable
  mem_wdata  in  64  ALU result or effective address
  mem_op  in  4  memory op code: NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  mem_sdata  in  64  store data
  mem_ready  out  1  stage accepts an instruction this cycle
REQ-003 SHALL have these data-memory ports:
  dmem_req  out  1  request valid
  dmem_we  out  1  store
  dmem_addr  out  64  8-byte-aligned address
  dmem_wdata  out  64  lane-shifted store data
  dmem_wmask  out  8  byte enables
  dmem_gnt  in  1  request accepted
  dmem_rvalid  in  1  load data valid
  dmem_rdata  in  64  load doubleword
REQ-004 SHALL have these writeback ports:
  wb_valid  out  1  one-cycle retire pulse
  wb_wd  out  5  destination register
  wb_wreg  out  1  register write enable
  wb_wdata  out  64  result data
  misalign_err  out  1  one-cycle misalignment pulse

Function
REQ-005 SHALL implement FSM states IDLE, REQ and WAIT_RSP; mem_ready=1 only in IDLE.
REQ-006 Accept SHALL occur when mem_valid & mem_ready; accepted fields latch into internal registers.
REQ-007 op NONE accepted in IDLE SHALL produce wb_valid=1 next cycle, wb_wdata=mem_wdata, wb_wd=mem_wd, wb_wreg=mem_wreg; FSM stays IDLE (1-cycle latency, back-to-back at full rate).
REQ-008 Aligned load/store accepted SHALL move to REQ; dmem_req held 1 with stable dmem_addr, dmem_we, dmem_wdata and dmem_wmask until dmem_gnt.
REQ-009 Store with dmem_gnt in REQ SHALL go to IDLE and pulse wb_valid=1 with wb_wreg=0 next cycle.
REQ-010 Load with dmem_gnt in REQ SHALL go to WAIT_RSP; dmem_rvalid SHALL be ignored in REQ and IDLE.
REQ-011 dmem_rvalid in WAIT_RSP SHALL go to IDLE and pulse wb_valid=1 next cycle with the extracted load data.
REQ-012 Load extraction SHALL select the byte/half/word at addr[2:0] and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits; LD passes dmem_rdata unchanged.
REQ-013 Store SHALL shift mem_sdata left by 8*addr[2:0]; wmask is 0x01/0x03/0x0F/0xFF for B/H/W/D, shifted left by addr[2:0].
REQ-014 dmem_addr SHALL be {addr[63:3],3'b000}.
REQ-015 Misalignment (H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0) SHALL issue no dmem_req, stay IDLE, and next cycle pulse wb_valid=1 with wb_wreg=0 and misalign_err=1.
REQ-016 wb_wreg SHALL be forced 0 whenever wb_wd=0.
REQ-017 All wb_* outputs and misalign_err SHALL be registered; wb_valid and misalign_err are high for exactly one cycle per instruction.

Reset
REQ-018 Reset SHALL force IDLE and set dmem_req=0, wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0 and misalign_err=0; all other outputs SHALL be 0 in reset.
REQ-019 Reset mid-transaction (REQ or WAIT_RSP) SHALL drop the instruction with no wb pulse; a late dmem_rvalid after reset SHALL be ignored.

Structure
REQ-020 Op codes, FSM state encodings and the widths 5/64/8 SHALL live in the shared defines package.
REQ-021 SHALL instantiate one combinational sub-module, load_align (rdata, addr[2:0], op -> 64-bit result).

Verification
REQ-022 ALU op: wdata=0x1234, wd=5, wreg=1 -> next cycle wb_valid=1, wb_wdata=0x1234, wb_wd=5.
REQ-023 LB at addr 0x1003 with rdata=0x00000000_80000000, gnt after 2 cycles, rvalid 1 cycle later -> wb_wdata=0xFFFFFFFF_FFFFFF80, dmem_addr=0x1000.
REQ-024 SH at addr 0x2006 with sdata=0xBEEF -> wmask=0xC0, wdata=0xBEEF0000_00000000, wb_wreg=0.
REQ-025 LW at addr 0x3002 -> no dmem_req; misalign_err=1 for one cycle; wb_wreg=0.
REQ-026 Reset asserted in WAIT_RSP, then rvalid=1 -> no wb_valid; mem_ready=1 the cycle after reset.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared op codes, FSM encodings, widths and op decode helpers
package mem_lsu_pkg;
  localparam int REG_W = 5;
  localparam int XLEN = 64;
  localparam int MASK_W = 8;
  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LD = 4'd4,
                         OP_LBU = 4'd5, OP_LHU = 4'd6, OP_LWU = 4'd7, OP_SB = 4'd8, OP_SH = 4'd9,
                         OP_SW = 4'd10, OP_SD = 4'd11;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2;
  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input logic [3:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? 2'd0 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd1 :
           (op == OP_LW || op == OP_LWU || op == OP_SW) ? 2'd2 : 2'd3;
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op >= OP_LB && op <= OP_SD;
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op >= OP_SB && op <= OP_SD;
  endfunction
  function automatic logic misaligned(input logic [3:0] op, input logic [2:0] off);
    logic [1:0] sz;
    sz = op_size(op);
    return is_mem(op) && (sz == 2'd1 ? off[0] : sz == 2'd2 ? |off[1:0] : sz == 2'd3 ? |off : 1'b0);
  endfunction
  function automatic logic [MASK_W-1:0] byte_mask(input logic [1:0] sz);
    return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: upstream, data-memory and writeback signals of the load/store unit
interface mem_lsu_if;
  import mem_lsu_pkg::*;
  logic              mem_valid;
  logic [REG_W-1:0]  mem_wd;
  logic              mem_wreg;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_op;
  logic [XLEN-1:0]   mem_sdata;
  logic              mem_ready;
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [MASK_W-1:0] dmem_wmask;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_wd;
  logic              wb_wreg;
  logic [XLEN-1:0]   wb_wdata;
  logic              misalign_err;
  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_op, mem_sdata, dmem_gnt, dmem_rvalid, dmem_rdata,
    output mem_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output wb_valid, wb_wd, wb_wreg, wb_wdata, misalign_err
  );
  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_op, mem_sdata, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  mem_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata, misalign_err
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// load_align: picks the addressed byte/half/word out of a doubleword and extends it
module load_align
  import mem_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o
);
  logic [XLEN-1:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};
  assign result_o = op_i == OP_LB  ? {{56{sh[7]}}, sh[7:0]} :
                    op_i == OP_LH  ? {{48{sh[15]}}, sh[15:0]} :
                    op_i == OP_LW  ? {{32{sh[31]}}, sh[31:0]} :
                    op_i == OP_LBU ? {56'd0, sh[7:0]} :
                    op_i == OP_LHU ? {48'd0, sh[15:0]} :
                    op_i == OP_LWU ? {32'd0, sh[31:0]} : rdata_i;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with single outstanding data-memory request
module mem_lsu
  import mem_lsu_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  mem_lsu_if.slave  bus
);
  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [REG_W-1:0]  wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [XLEN-1:0]   st_data_q, st_data_d;
  logic [MASK_W-1:0] st_mask_q, st_mask_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;
  logic              err_q, err_d;
  logic              acc, mem, mis;
  logic [XLEN-1:0]   ld_data;
  load_align u_align (
    .rdata_i  (bus.dmem_rdata),
    .off_i    (addr_q[2:0]),
    .op_i     (op_q),
    .result_o (ld_data)
  );
  assign acc = bus.mem_valid && state_q == ST_IDLE;
  assign mem = is_mem(bus.mem_op);
  assign mis = misaligned(bus.mem_op, bus.mem_wdata[2:0]);
  // Reset is combinationally folded into the bus-facing outputs so they read 0 during reset
  assign bus.mem_ready  = !rst_n && state_q == ST_IDLE;
  assign bus.dmem_req   = !rst_n && state_q == ST_REQ;
  assign bus.dmem_we    = bus.dmem_req && is_store(op_q);
  assign bus.dmem_addr  = rst_n ? '0 : {addr_q[XLEN-1:3], 3'b000};
  assign bus.dmem_wdata = rst_n ? '0 : st_data_q;
  assign bus.dmem_wmask = rst_n ? '0 : st_mask_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_wd        = wb_wd_q;
  assign bus.wb_wreg      = wb_wreg_q;
  assign bus.wb_wdata     = wb_wdata_q;
  assign bus.misalign_err = err_q;
  // Next state: accept in IDLE, hold the request until grant, then wait for load data
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wd_d = wd_q;
    wreg_d = wreg_q;
    st_data_d = st_data_q;
    st_mask_d = st_mask_q;
    wb_valid_d = 1'b0;
    wb_wd_d = wb_wd_q;
    wb_wreg_d = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    err_d = 1'b0;
    if (acc && (!mem || mis)) begin
      wb_valid_d = 1'b1;
      wb_wd_d = bus.mem_wd;
      wb_wreg_d = !mem && bus.mem_wreg && |bus.mem_wd;
      wb_wdata_d = mem ? '0 : bus.mem_wdata;
      err_d = mem;
    end else if (acc) begin
      state_d = ST_REQ;
      op_d = bus.mem_op;
      addr_d = bus.mem_wdata;
      wd_d = bus.mem_wd;
      wreg_d = bus.mem_wreg;
      st_data_d = bus.mem_sdata << {bus.mem_wdata[2:0], 3'b000};
      st_mask_d = byte_mask(op_size(bus.mem_op)) << bus.mem_wdata[2:0];
    end
    if (state_q == ST_REQ && bus.dmem_gnt) begin
      state_d = is_store(op_q) ? ST_IDLE : ST_WAIT;
      wb_valid_d = is_store(op_q);
      wb_wd_d = is_store(op_q) ? wd_q : wb_wd_q;
      wb_wreg_d = is_store(op_q) ? 1'b0 : wb_wreg_q;
      wb_wdata_d = is_store(op_q) ? '0 : wb_wdata_q;
    end
    if (state_q == ST_WAIT && bus.dmem_rvalid) begin
      state_d = ST_IDLE;
      wb_valid_d = 1'b1;
      wb_wd_d = wd_q;
      wb_wreg_d = wreg_q && |wd_q;
      wb_wdata_d = ld_data;
    end
  end
  // State and registered writeback outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      op_q <= OP_NONE;
      addr_q <= '0;
      wd_q <= '0;
      wreg_q <= 1'b0;
      st_data_q <= '0;
      st_mask_q <= '0;
      wb_valid_q <= 1'b0;
      wb_wd_q <= '0;
      wb_wreg_q <= 1'b0;
      wb_wdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      wreg_q <= wreg_d;
      st_data_q <= st_data_d;
      st_mask_q <= st_mask_d;
      wb_valid_q <= wb_valid_d;
      wb_wd_q <= wb_wd_d;
      wb_wreg_q <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a byte-level reference model
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_lsu_if bus();
  mem_lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic [63:0] model_load(input logic [3:0] op, input int off, input logic [63:0] rdata);
    logic [63:0] v;
    int n;
    n = nbytes(op);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (op inside {OP_LB, OP_LH, OP_LW} && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic txn(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                     input logic [63:0] rdata, input logic [4:0] wd, input logic wreg,
                     input int g, input int r,
                     output logic [63:0] wb_obs, output logic [7:0] mask_obs, output logic [63:0] wdat_obs);
    int n, off;
    bit mis;
    logic [7:0] exp_mask;
    n = nbytes(op);
    off = int'(addr[2:0]);
    mis = op != OP_NONE && (off % n) != 0;
    exp_mask = 8'(((1 << n) - 1) << off);
    wb_obs = '0;
    mask_obs = '0;
    wdat_obs = '0;
    bus.mem_valid = 1'b1;
    bus.mem_op = op;
    bus.mem_wdata = addr;
    bus.mem_sdata = sdata;
    bus.mem_wd = wd;
    bus.mem_wreg = wreg;
    @(negedge clk);
    chk1("ready_idle", bus.mem_ready, 1'b1);
    step;
    bus.mem_valid = 1'b0;
    if (op == OP_NONE || mis) begin
      @(negedge clk);
      chk1("wb_valid_fast", bus.wb_valid, 1'b1);
      chk("wb_wd_fast", 64'(bus.wb_wd), 64'(wd));
      chk1("wb_wreg_fast", bus.wb_wreg, op == OP_NONE && wreg && wd != 0);
      chk1("misalign_err", bus.misalign_err, mis);
      chk1("no_req", bus.dmem_req, 1'b0);
      if (op == OP_NONE) chk("wb_wdata_alu", bus.wb_wdata, addr);
      wb_obs = bus.wb_wdata;
      step;
      @(negedge clk);
      chk1("wb_pulse_end", bus.wb_valid, 1'b0);
      chk1("misalign_end", bus.misalign_err, 1'b0);
      step;
    end else begin
      for (int k = 0; k <= g; k++) begin
        bus.dmem_gnt = k == g;
        bus.dmem_rvalid = 1'($urandom_range(0, 1));
        bus.dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk1("req_held", bus.dmem_req, 1'b1);
        chk("req_addr", bus.dmem_addr, {addr[63:3], 3'b000});
        chk1("req_we", bus.dmem_we, is_st(op));
        chk1("req_not_ready", bus.mem_ready, 1'b0);
        chk1("req_no_wb", bus.wb_valid, 1'b0);
        if (is_st(op)) begin
          chk("req_wmask", 64'(bus.dmem_wmask), 64'(exp_mask));
          chk("req_wdata", bus.dmem_wdata, sdata << (8 * off));
        end
        mask_obs = bus.dmem_wmask;
        wdat_obs = bus.dmem_wdata;
        step;
      end
      bus.dmem_gnt = 1'b0;
      bus.dmem_rvalid = 1'b0;
      if (is_st(op)) begin
        @(negedge clk);
        chk1("st_wb_valid", bus.wb_valid, 1'b1);
        chk1("st_wb_wreg", bus.wb_wreg, 1'b0);
        chk("st_wb_wd", 64'(bus.wb_wd), 64'(wd));
        chk1("st_no_err", bus.misalign_err, 1'b0);
        chk1("st_req_drop", bus.dmem_req, 1'b0);
        step;
        @(negedge clk);
        chk1("st_pulse_end", bus.wb_valid, 1'b0);
        step;
      end else begin
        for (int k = 0; k <= r; k++) begin
          bus.dmem_rvalid = k == r;
          bus.dmem_rdata = (k == r) ? rdata : {$urandom, $urandom};
          @(negedge clk);
          chk1("wait_no_wb", bus.wb_valid, 1'b0);
          chk1("wait_no_req", bus.dmem_req, 1'b0);
          chk1("wait_not_ready", bus.mem_ready, 1'b0);
          step;
        end
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk1("ld_wb_valid", bus.wb_valid, 1'b1);
        chk("ld_wb_wd", 64'(bus.wb_wd), 64'(wd));
        chk1("ld_wb_wreg", bus.wb_wreg, wreg && wd != 0);
        chk("ld_wb_wdata", bus.wb_wdata, model_load(op, off, rdata));
        chk1("ld_no_err", bus.misalign_err, 1'b0);
        wb_obs = bus.wb_wdata;
        step;
        @(negedge clk);
        chk1("ld_pulse_end", bus.wb_valid, 1'b0);
        step;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] o, w;
    logic [7:0] m;
    bus.mem_valid = 0; bus.mem_wd = 0; bus.mem_wreg = 0; bus.mem_wdata = 0; bus.mem_op = OP_NONE;
    bus.mem_sdata = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
    rst_n = 1'b1;
    step;
    step;
    @(negedge clk);
    chk1("rst_ready", bus.mem_ready, 1'b0);
    chk1("rst_req", bus.dmem_req, 1'b0);
    chk1("rst_we", bus.dmem_we, 1'b0);
    chk("rst_addr", bus.dmem_addr, 64'd0);
    chk("rst_wmask", 64'(bus.dmem_wmask), 64'd0);
    chk("rst_wdata", bus.dmem_wdata, 64'd0);
    chk1("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_wb_wd", 64'(bus.wb_wd), 64'd0);
    chk1("rst_wb_wreg", bus.wb_wreg, 1'b0);
    chk("rst_wb_wdata", bus.wb_wdata, 64'd0);
    chk1("rst_err", bus.misalign_err, 1'b0);
    step;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("ready_after_rst", bus.mem_ready, 1'b1);
    step;
    txn(OP_NONE, 64'h1234, 64'd0, 64'd0, 5'd5, 1'b1, 0, 0, o, m, w);
    chk("alu_result", o, 64'h1234);
    txn(OP_NONE, 64'h55, 64'd0, 64'd0, 5'd0, 1'b1, 0, 0, o, m, w);
    bus.mem_valid = 1'b1; bus.mem_op = OP_NONE; bus.mem_wdata = 64'hA1; bus.mem_wd = 5'd1; bus.mem_wreg = 1'b1;
    step;
    bus.mem_wdata = 64'hB2; bus.mem_wd = 5'd2;
    @(negedge clk);
    chk1("b2b_valid0", bus.wb_valid, 1'b1);
    chk("b2b_data0", bus.wb_wdata, 64'hA1);
    chk1("b2b_ready", bus.mem_ready, 1'b1);
    step;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_valid1", bus.wb_valid, 1'b1);
    chk("b2b_data1", bus.wb_wdata, 64'hB2);
    chk("b2b_wd1", 64'(bus.wb_wd), 64'd2);
    step;
    txn(OP_LB, 64'h1003, 64'd0, 64'h00000000_80000000, 5'd7, 1'b1, 2, 0, o, m, w);
    chk("lb_sext", o, 64'hFFFFFFFF_FFFFFF80);
    txn(OP_SH, 64'h2006, 64'hBEEF, 64'd0, 5'd3, 1'b1, 0, 0, o, m, w);
    chk("sh_mask", 64'(m), 64'hC0);
    chk("sh_wdata", w, 64'hBEEF0000_00000000);
    txn(OP_LW, 64'h3002, 64'd0, 64'd0, 5'd4, 1'b1, 0, 0, o, m, w);
    txn(OP_LD, 64'h4008, 64'd0, 64'h01234567_89ABCDEF, 5'd9, 1'b1, 0, 2, o, m, w);
    chk("ld_pass", o, 64'h01234567_89ABCDEF);
    txn(OP_LHU, 64'h500E, 64'd0, 64'hF00D0000_00000000, 5'd6, 1'b1, 1, 1, o, m, w);
    chk("lhu_zext", o, 64'h0000_0000_0000_F00D);
    bus.mem_valid = 1'b1; bus.mem_op = OP_LD; bus.mem_wdata = 64'h6000; bus.mem_wd = 5'd8; bus.mem_wreg = 1'b1;
    step;
    bus.mem_valid = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    chk1("rstw_req", bus.dmem_req, 1'b1);
    step;
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk1("rstw_in_wait", bus.mem_ready, 1'b0);
    step;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rstw_no_wb0", bus.wb_valid, 1'b0);
    step;
    rst_n = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk1("rstw_ready", bus.mem_ready, 1'b1);
    chk1("rstw_no_wb1", bus.wb_valid, 1'b0);
    step;
    bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    chk1("rstw_no_wb2", bus.wb_valid, 1'b0);
    chk1("rstw_no_req", bus.dmem_req, 1'b0);
    step;
    for (int t = 0; t < 60; t++) begin
      logic [3:0] op;
      logic [63:0] addr, sd, rd;
      op = 4'($urandom_range(0, 11));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr = addr & ~64'(nbytes(op) - 1);
      sd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      txn(op, addr, sd, rd, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3), o, m, w);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
